// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one data RAM between the CPU load/store stage and the
// debug/loader port. At most one RAM operation is issued per cycle. The CPU
// normally wins, but a streak counter caps how long debug can be held off.
// Read data returns one cycle after the grant, to the port that issued it.
module ram_arbiter #(
  parameter int AWIDTH       = 8,
  parameter int DWIDTH       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [AWIDTH-1:0] c_addr,
  input  logic [DWIDTH-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DWIDTH-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [AWIDTH-1:0] ram_raddr,
  output logic [AWIDTH-1:0] ram_waddr,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdata,
  output logic [3:0]        starve_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;   // 1 = debug owns the pending read

  // Grant decision: CPU first unless its streak has reached the limit while debug waits.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (c_req && (!d_req || (starve_cnt_q < LIMIT))) begin
        c_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // The stall is forced low in reset so every output reads 0 while rst is held.
  assign c_stall = c_req & ~c_gnt & ~rst;

  // RAM strobes, addresses and write data steered from the winning port; idle fields stay 0.
  always_comb begin
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    ram_raddr = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (c_gnt) begin
      if (c_we) begin
        ram_wr    = 1'b1;
        ram_waddr = c_addr;
        ram_wdata = c_wdata;
      end else begin
        ram_rd    = 1'b1;
        ram_raddr = c_addr;
      end
    end else if (d_gnt) begin
      if (d_we) begin
        ram_wr    = 1'b1;
        ram_waddr = d_addr;
        ram_wdata = d_wdata;
      end else begin
        ram_rd    = 1'b1;
        ram_raddr = d_addr;
      end
    end
  end

  // Next-state for the CPU streak counter and the read-return owner flag.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!d_req || d_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (c_gnt && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    rd_pend_d  = (c_gnt & ~c_we) | (d_gnt & ~d_we);
    rd_owner_d = d_gnt;
  end

  // Control state registers; reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Read return: the owner sees the RAM data, the other port sees 0.
  always_comb begin
    c_rvalid = rd_pend_q & ~rd_owner_q & ~rst;
    d_rvalid = rd_pend_q &  rd_owner_q & ~rst;
    c_rdata  = c_rvalid ? ram_rdata : '0;
    d_rdata  = d_rvalid ? ram_rdata : '0;
  end

  assign starve_cnt = starve_cnt_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single data RAM between the CPU load/store stage and a debug/loader port. It issues at most one RAM operation per cycle and returns read data to the port that issued the read. The CPU has priority, bounded by a starvation limit so the debug port always makes progress. It sits between the CPU memory-access stage, the debug bridge and the RAM instance.

## Interface
Parameters:
- AWIDTH, 8, RAM address width
- DWIDTH, 16, RAM data width
- STARVE_LIMIT, 4, max consecutive CPU grants while debug is waiting (range 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- c_req  in  1  CPU access request
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  AWIDTH  CPU address
- c_wdata  in  DWIDTH  CPU write data
- c_gnt  out  1  CPU request accepted this cycle
- c_stall  out  1  c_req & ~c_gnt, to CPU pipeline hold
- c_rvalid  out  1  CPU read data valid
- c_rdata  out  DWIDTH  CPU read data
- d_req, d_we, d_addr, d_wdata  in  1/1/AWIDTH/DWIDTH  debug-port equivalents
- d_gnt, d_rvalid  out  1  debug-port equivalents
- d_rdata  out  DWIDTH  debug read data
- ram_rd, ram_wr  out  1  RAM strobes
- ram_raddr, ram_waddr  out  AWIDTH  RAM addresses
- ram_wdata  out  DWIDTH  RAM write data
- ram_rdata  in  DWIDTH  RAM read data, valid the cycle after ram_rd
- starve_cnt  out  4  current CPU streak count (debug visibility)

## Operation
- Request rule: requester holds req/we/addr/wdata stable until it sees gnt high; the cycle with req&gnt is the transfer. req may stay high for back-to-back transfers.
- Grant decision (combinational from req inputs and starve_cnt):
  - only c_req: CPU granted; only d_req: debug granted.
  - both: CPU granted if starve_cnt < STARVE_LIMIT, else debug granted.
  - c_gnt and d_gnt are never high together.
- starve_cnt (registered): +1 on a CPU grant while d_req high (saturates at STARVE_LIMIT); cleared on any debug grant or any cycle with d_req low.
- RAM drive in the grant cycle (combinational from the winner): we=1 -> ram_wr=1, ram_waddr=addr, ram_wdata=wdata; we=0 -> ram_rd=1, ram_raddr=addr. Unused address/data outputs are driven 0. No grant -> ram_rd=ram_wr=0.
- Read return: registered owner flag rd_pend/rd_owner set on a read grant; next cycle the owner's rvalid=1 and rdata=ram_rdata; the other port's rdata is 0.
- A write followed next cycle by a read of the same address returns the new data (RAM write-first ordering is guaranteed by the single op per cycle).

## Timing
- Reset: all outputs 0; starve_cnt=0; rd_pend=0. Reset asserted while a read is in flight drops it: no rvalid after reset.
- Grant latency 0 cycles (same cycle as req when it wins); read data latency 1 cycle after grant; write completes in the grant cycle.
- Throughput: one transfer per cycle, reads can be issued every cycle (rvalid pipelines back-to-back).
- Worst-case debug wait with continuous CPU traffic: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1.
- c_stall is purely combinational; the CPU must not use it to gate c_req (no loop).

## Test plan
- Reset: hold rst 2 cycles with c_req=d_req=1 -> all grants, strobes, rvalid = 0; starve_cnt=0.
- CPU write 0xBEEF @0x10, next cycle CPU read @0x10 -> c_gnt both cycles, ram_wr then ram_rd, c_rvalid=1 with c_rdata=0xBEEF one cycle after read grant; d_rvalid=0.
- Contention, STARVE_LIMIT=4, both reqs held high -> grant pattern C,C,C,C,D repeating; starve_cnt 0,1,2,3,4,0; c_stall high exactly on D cycles.
- Debug-only back-to-back reads @0x00..0x03 preloaded 1..4 -> d_gnt every cycle, d_rvalid 4 consecutive cycles with data 1,2,3,4.
- d_req drops at starve_cnt=3 -> starve_cnt cleared to 0 next cycle; subsequent contention starts a fresh streak.
- Read granted then rst asserted next cycle -> no c_rvalid/d_rvalid emitted; first post-reset request granted normally.
